// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder, one bit pair per clock, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add a registered two's-complement overflow output (ovf).

module full_adder_design (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Handshake: start is accepted on any edge where the FSM is in IDLE or DONE; busy marks
// the WIDTH shift cycles; done is a one-cycle pulse with sum/cout (and ovf) already valid.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_s, fa_cout;
   logic last_bit, accept;

   full_adder_design u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign last_bit = (cnt_q == CW'(WIDTH - 1));
   assign accept   = start && (state_q != ST_SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_d = ST_DONE;
         ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d    = ovf_q;
`endif
      if (accept) begin
         a_sr_d  = a;
         b_sr_d  = b;
         carry_d = cin;
         cnt_d   = '0;
      end else if (state_q == ST_SHIFT) begin
         a_sr_d   = a_sr_q >> 1;
         b_sr_d   = b_sr_q >> 1;
         sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
         carry_d  = fa_cout;
         // Counter returns to 0 on the last bit so it never exceeds WIDTH-1.
         cnt_d    = last_bit ? '0 : cnt_q + CW'(1);
         if (last_bit) begin
            sum_d  = {fa_s, sum_sr_q[WIDTH-1:1]};
            cout_d = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is the carry into the MSB on the last bit.
            ovf_d  = carry_q ^ fa_cout;
`endif
         end
      end
   end

   always_comb begin
      busy = (state_q == ST_SHIFT);
      done = (state_q == ST_DONE);
   end

   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): queued expected results, done-driven monitor.

module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy, done, cout;
   logic [W-1:0] sum;
   logic         ovf_v;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
   assign ovf_v = ovf;
`else
   assign ovf_v = 1'b0;
`endif

   logic [W+1:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference result packed as {ovf, cout, sum}.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] t;
      logic       o;
      t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
`ifdef SERIAL_ADDER_OVF_EN
      o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
`else
      o = 1'b0;
`endif
      return {o, t};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [W+1:0] e;
      if (busy && done) begin
         tests++;
         fails++;
         $display("[TB] FAIL busy_done_overlap: busy=%0b done=%0b expected not both high", busy, done);
      end
      if (done) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_done: got done with no result queued, expected none");
         end else begin
            e = exp_q.pop_front();
            if ({ovf_v, cout, sum} !== e) begin
               fails++;
               $display("[TB] FAIL result: got ovf=%0b cout=%0b sum=0x%0h expected ovf=%0b cout=%0b sum=0x%0h",
                        ovf_v, cout, sum, e[W+1], e[W], e[W-1:0]);
            end
         end
      end
   end

   // Presents operands with start for one clock; returns just after the accepting edge.
   task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = x;
      b     = y;
      cin   = c;
      exp_q.push_back(model(x, y, c));
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input string name, input bit chk_lat);
      int  nb   = 0;
      int  k    = 0;
      bit  seen = 1'b0;
      for (int i = 1; i <= 2 * W + 4 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            k    = i;
         end else if (busy) begin
            nb++;
         end
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      if (chk_lat) begin
         check({name, "_busy_cycles"}, 32'(nb), 32'(W));
         check({name, "_done_cycle"}, 32'(k), 32'(W + 1));
      end
   endtask

   initial begin
      int nd;
      #12;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
      check("reset_ovf", 32'(ovf_v), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      pulse_start(8'h00, 8'h00, 1'b0);
      wait_done("zero", 1'b1);
      pulse_start(8'hFF, 8'h01, 1'b0);
      wait_done("ff_plus_1", 1'b1);

      // Back-to-back: start held high during the DONE cycle.
      pulse_start(8'h5A, 8'hA5, 1'b1);
      wait_done("5a_a5", 1'b1);
      start = 1'b1;
      a     = 8'h03;
      b     = 8'h04;
      cin   = 1'b0;
      exp_q.push_back(model(8'h03, 8'h04, 1'b0));
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("back_to_back", 1'b1);

      // A start pulse during SHIFT must be ignored.
      pulse_start(8'h10, 8'h20, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ignored_start", 1'b0);
      nd = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (busy || done) nd++;
      end
      check("no_restart_after_ignore", 32'(nd), 32'd0);

      // Reset in the middle of a shift discards the operation.
      pulse_start(8'h33, 8'h44, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      nd = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("no_done_after_reset", 32'(nd), 32'd0);
      pulse_start(8'h12, 8'h34, 1'b0);
      wait_done("after_reset", 1'b1);

      pulse_start(8'h7F, 8'h01, 1'b0);
      wait_done("pos_overflow", 1'b1);
      pulse_start(8'h80, 8'h80, 1'b0);
      wait_done("neg_overflow", 1'b1);

      for (int i = 0; i < 20; i++) begin
         pulse_start(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         wait_done("random", 1'b1);
      end

      repeat (2) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
